// File: rtl/image_blit_pipe.sv
// image_blit_pipe: ROM image overlay for the VGA path.
// Maps VGA_X/VGA_Y to a ROM address and returns a latency-aligned draw flag and pixel.
module image_blit_pipe #(
    parameter int          P_IMAGE_WIDTH  = 80,
    parameter int          P_IMAGE_HEIGHT = 480,
    parameter int          P_COORD_W      = 11,
    parameter int          P_ADDR_W       = 16,
    parameter int          P_ROM_LATENCY  = 1,
    parameter int          P_SCALE_MAX    = 2,
    parameter logic [23:0] P_KEY_COLOR    = 24'h000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [P_COORD_W-1:0] VGA_X,
    input  logic [P_COORD_W-1:0] VGA_Y,
    input  logic                 frame_start,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [P_COORD_W-1:0] cfg_x,
    input  logic [P_COORD_W-1:0] cfg_y,
    input  logic [1:0]           cfg_scale,
    input  logic [1:0]           cfg_mirror,
    input  logic                 cfg_key_en,
    input  logic                 cfg_enable,
    output logic [P_ADDR_W-1:0]  rom_addr,
    input  logic [23:0]          rom_q,
    output logic                 draw_image,
    output logic [7:0]           image_R,
    output logic [7:0]           image_G,
    output logic [7:0]           image_B
);

    // One bit of headroom so differences near the screen edge never wrap.
    localparam int LW = P_COORD_W + 1;

    typedef struct packed {
        logic [P_COORD_W-1:0] x;
        logic [P_COORD_W-1:0] y;
        logic [1:0]           scale;
        logic [1:0]           mirror;
        logic                 key_en;
        logic                 enable;
    } place_t;

    place_t r_pend;
    place_t r_act;
    logic   r_pend_v;

    place_t w_cfg_in;
    logic   w_xfer;
    logic   w_swap;

    logic signed [LW-1:0] w_dx;
    logic signed [LW-1:0] w_dy;
    logic signed [LW-1:0] w_lx;
    logic signed [LW-1:0] w_ly;
    logic [LW-1:0]        w_lxm;
    logic [LW-1:0]        w_lym;
    logic [1:0]           w_s;
    logic                 w_inside;
    logic [P_ADDR_W-1:0]  w_addr;

    logic [P_ROM_LATENCY:0] r_v;
    logic [P_ROM_LATENCY:0] r_key;
    logic [P_ADDR_W-1:0]    r_rom_addr;
    logic                   r_draw;
    logic [23:0]            r_rgb;
    logic                   w_draw;

    assign w_cfg_in = '{
        x:      cfg_x,
        y:      cfg_y,
        scale:  cfg_scale,
        mirror: cfg_mirror,
        key_en: cfg_key_en,
        enable: cfg_enable
    };

    assign cfg_ready = !r_pend_v;
    assign w_xfer    = cfg_valid && !r_pend_v;
    assign w_swap    = frame_start && r_pend_v;

    // Double-buffered placement: accept into pending, promote at frame start.
    // A swap needs pending=1, so it never coincides with a transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend   <= '0;
            r_act    <= '0;
            r_pend_v <= 1'b0;
        end else if (w_swap) begin
            r_act    <= r_pend;
            r_pend_v <= 1'b0;
        end else if (w_xfer) begin
            r_pend   <= w_cfg_in;
            r_pend_v <= 1'b1;
        end
    end

    // Stage 0: screen position to texel coordinate, clip test, mirror, address.
    always_comb begin
        w_s = r_act.scale;
        if (r_act.scale > 2'(P_SCALE_MAX)) begin
            w_s = 2'(P_SCALE_MAX);
        end
        w_dx = $signed({1'b0, VGA_X}) - $signed({1'b0, r_act.x});
        w_dy = $signed({1'b0, VGA_Y}) - $signed({1'b0, r_act.y});
        w_lx = w_dx >>> w_s;
        w_ly = w_dy >>> w_s;
        w_inside = r_act.enable
                && !w_dx[LW-1]
                && !w_dy[LW-1]
                && (w_lx < $signed(LW'(P_IMAGE_WIDTH)))
                && (w_ly < $signed(LW'(P_IMAGE_HEIGHT)));
        w_lxm = $unsigned(w_lx);
        if (r_act.mirror[0]) begin
            w_lxm = LW'(P_IMAGE_WIDTH - 1) - $unsigned(w_lx);
        end
        w_lym = $unsigned(w_ly);
        if (r_act.mirror[1]) begin
            w_lym = LW'(P_IMAGE_HEIGHT - 1) - $unsigned(w_ly);
        end
        w_addr = P_ADDR_W'(w_lym) * P_ADDR_W'(P_IMAGE_WIDTH)
               + P_ADDR_W'(w_lxm);
    end

    // Stage 1: register the ROM address and launch valid/key along the ROM delay.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rom_addr <= '0;
            r_v        <= '0;
            r_key      <= '0;
        end else begin
            r_rom_addr <= w_inside ? w_addr : '0;
            r_v        <= {r_v[P_ROM_LATENCY-1:0], w_inside};
            r_key      <= {r_key[P_ROM_LATENCY-1:0], r_act.key_en};
        end
    end

    // Key test uses the key setting that travelled with this pixel.
    assign w_draw = r_v[P_ROM_LATENCY]
                 && !(r_key[P_ROM_LATENCY] && (rom_q == P_KEY_COLOR));

    // Output stage: draw flag and colour, zeroed when not drawing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_draw <= 1'b0;
            r_rgb  <= '0;
        end else begin
            r_draw <= w_draw;
            r_rgb  <= w_draw ? rom_q : '0;
        end
    end

    assign rom_addr   = r_rom_addr;
    assign draw_image = r_draw;
    assign image_R    = r_rgb[23:16];
    assign image_G    = r_rgb[15:8];
    assign image_B    = r_rgb[7:0];

endmodule

// File: tb/tb_image_blit_pipe.sv
// tb_image_blit_pipe: scoreboard bench for image_blit_pipe.
// Behavioural ROM, placement model and expected-output queues.
module tb_image_blit_pipe;

    localparam int CW = 11;
    localparam int AW = 16;
    localparam int L  = 1;
    localparam int IW = 80;
    localparam int IH = 480;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [1:0]    scale;
        logic [1:0]    mirror;
        logic          key;
        logic          en;
    } cfg_t;

    typedef struct packed {
        logic        draw;
        logic [23:0] rgb;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] VGA_X;
    logic [CW-1:0] VGA_Y;
    logic          frame_start;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [AW-1:0] rom_addr;
    logic [23:0]   rom_q;
    logic          draw_image;
    logic [7:0]    image_R;
    logic [7:0]    image_G;
    logic [7:0]    image_B;

    cfg_t d_cfg;
    cfg_t nx_cfg;
    cfg_t m_act;
    cfg_t m_pend;
    logic m_pv;

    exp_t          eq[$];
    logic [AW-1:0] aq[$];
    logic [23:0]   rom_pipe[L];

    int n_checks = 0;
    int n_errors = 0;
    int lit_addr = -1;

    always #5 clk = ~clk;

    image_blit_pipe #(
        .P_IMAGE_WIDTH (IW),
        .P_IMAGE_HEIGHT(IH),
        .P_COORD_W     (CW),
        .P_ADDR_W      (AW),
        .P_ROM_LATENCY (L),
        .P_SCALE_MAX   (2),
        .P_KEY_COLOR   (24'h000000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .VGA_X      (VGA_X),
        .VGA_Y      (VGA_Y),
        .frame_start(frame_start),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_x      (d_cfg.x),
        .cfg_y      (d_cfg.y),
        .cfg_scale  (d_cfg.scale),
        .cfg_mirror (d_cfg.mirror),
        .cfg_key_en (d_cfg.key),
        .cfg_enable (d_cfg.en),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .draw_image (draw_image),
        .image_R    (image_R),
        .image_G    (image_G),
        .image_B    (image_B)
    );

    function automatic logic [23:0] romf(input logic [AW-1:0] a);
        if (a == 16'd1) return 24'h000000;
        if (a == 16'd2) return 24'h123456;
        return {a[15:8] ^ 8'h5A, a[7:0], 8'hC3};
    endfunction

    // ROM with L clocks from address to data
    always @(posedge clk) begin
        rom_pipe[0] <= romf(rom_addr);
        for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_q = rom_pipe[L-1];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input int vx, input int vy, input cfg_t c,
                         output logic ins, output logic [AW-1:0] ad);
        int dx, dy, lx, ly, s;
        dx = vx - int'(c.x);
        dy = vy - int'(c.y);
        s  = (int'(c.scale) > 2) ? 2 : int'(c.scale);
        lx = dx >>> s;
        ly = dy >>> s;
        ins = c.en && dx >= 0 && dy >= 0 && lx < IW && ly < IH;
        if (c.mirror[0]) lx = IW - 1 - lx;
        if (c.mirror[1]) ly = IH - 1 - ly;
        ad = ins ? AW'(ly * IW + lx) : '0;
    endtask

    task automatic cyc(input int vx, input int vy, input logic fs = 1'b0,
                       input logic cv = 1'b0, input logic rn = 1'b1);
        exp_t          e;
        logic          ins;
        logic [AW-1:0] ad;
        logic [23:0]   d;
        @(posedge clk);
        #1;
        if (!reset) begin
            m_act = '0; m_pend = '0; m_pv = 1'b0;
        end else if (frame_start && m_pv) begin
            m_act = m_pend; m_pv = 1'b0;
        end else if (cfg_valid && !m_pv) begin
            m_pend = d_cfg; m_pv = 1'b1;
        end
        check("cfg_ready", 32'(cfg_ready), 32'(!m_pv));
        e = eq.pop_front();
        check("draw", 32'(draw_image), 32'(e.draw));
        check("rgb", 32'({image_R, image_G, image_B}), 32'(e.rgb));
        check("rom_addr", 32'(rom_addr), 32'(aq.pop_front()));
        if (lit_addr >= 0) begin
            check("lit_addr", 32'(rom_addr), 32'(lit_addr));
            lit_addr = -1;
        end
        if (!rn && reset) begin
            foreach (eq[i]) eq[i] = '0;
            foreach (aq[i]) aq[i] = '0;
            m_act = '0; m_pend = '0; m_pv = 1'b0;
        end
        reset       = rn;
        VGA_X       = CW'(vx);
        VGA_Y       = CW'(vy);
        frame_start = fs;
        cfg_valid   = cv;
        d_cfg       = nx_cfg;
        if (!rn) begin
            eq.push_back('0);
            aq.push_back('0);
        end else begin
            model(vx, vy, m_act, ins, ad);
            d = romf(ad);
            e.draw = ins && !(m_act.key && d == 24'h000000);
            e.rgb  = e.draw ? d : 24'h0;
            eq.push_back(e);
            aq.push_back(ad);
        end
    endtask

    task automatic place(input int x, input int y, input int s, input int m,
                         input logic k, input logic en);
        nx_cfg = '{x: CW'(x), y: CW'(y), scale: 2'(s), mirror: 2'(m),
                   key: k, en: en};
        cyc(2047, 2047, 1'b0, 1'b1);
        cyc(2047, 2047, 1'b1, 1'b0);
        cyc(2047, 2047);
    endtask

    initial begin
        reset = 1'b0; VGA_X = '0; VGA_Y = '0;
        frame_start = 1'b0; cfg_valid = 1'b0;
        d_cfg = '0; nx_cfg = '0;
        m_act = '0; m_pend = '0; m_pv = 1'b0;
        for (int i = 0; i < L + 2; i++) eq.push_back('0);
        aq.push_back('0);

        // reset held with random activity
        for (int i = 0; i < 10; i++) begin
            nx_cfg.x = CW'($urandom_range(0, 2047));
            nx_cfg.y = CW'($urandom_range(0, 2047));
            nx_cfg.scale = 2'($urandom_range(0, 3));
            nx_cfg.mirror = 2'($urandom_range(0, 3));
            nx_cfg.key = 1'($urandom_range(0, 1));
            nx_cfg.en = 1'b1;
            cyc($urandom_range(0, 2047), $urandom_range(0, 2047),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        cyc(0, 0);

        // basic placement and right/bottom edges
        place(100, 64, 0, 0, 1'b0, 1'b1);
        cyc(100, 64); lit_addr = 0;
        cyc(179, 64); lit_addr = 79;
        cyc(180, 64);
        cyc(99, 64);
        cyc(100, 63);
        cyc(150, 543);
        cyc(150, 544);

        // scale, mirrors, scale clamp
        place(0, 0, 1, 0, 1'b0, 1'b1);
        cyc(3, 5); lit_addr = 161;
        cyc(159, 0);
        cyc(160, 0);
        place(0, 0, 0, 1, 1'b0, 1'b1);
        cyc(0, 0); lit_addr = 79;
        cyc(79, 0);
        place(0, 0, 0, 2, 1'b0, 1'b1);
        cyc(0, 0); lit_addr = 38320;
        place(0, 0, 3, 0, 1'b0, 1'b1);
        cyc(7, 0); lit_addr = 1;
        cyc(319, 0);
        cyc(320, 0);

        // handshake: pending blocks, coincident transfer waits a frame
        nx_cfg = '{x: 11'd0, y: 11'd0, scale: 2'd0, mirror: 2'd0, key: 1'b0, en: 1'b1};
        cyc(5, 5, 1'b0, 1'b1);
        nx_cfg.x = 11'd500;
        cyc(5, 5, 1'b0, 1'b1);
        cyc(5, 5, 1'b0, 1'b1);
        cyc(5, 5, 1'b1, 1'b0);
        cyc(5, 5);
        cyc(5, 5, 1'b1, 1'b1);
        cyc(5, 5);
        cyc(5, 5);
        cyc(5, 5, 1'b1, 1'b0);
        cyc(5, 5);
        cyc(505, 5);

        // colour key
        place(0, 0, 0, 0, 1'b1, 1'b1);
        cyc(1, 0);
        cyc(2, 0);
        cyc(3, 0);
        place(0, 0, 0, 0, 1'b0, 1'b1);
        cyc(1, 0);
        cyc(2, 0);

        // clipping at the right screen edge, no wrap
        place(2040, 10, 0, 0, 1'b0, 1'b1);
        for (int x = 2036; x < 2048; x++) cyc(x, 10);
        for (int x = 0; x < 4; x++) cyc(x, 10);

        // mid-line reset flushes the pipeline
        cyc(2041, 10);
        cyc(2042, 10);
        cyc(2043, 10, 1'b0, 1'b0, 1'b0);
        cyc(2044, 10, 1'b0, 1'b0, 1'b0);
        cyc(2045, 10);
        for (int i = 0; i < 4; i++) cyc(2046, 10);
        place(2040, 10, 0, 0, 1'b0, 1'b1);
        cyc(2046, 10);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            nx_cfg.x = CW'($urandom_range(0, 150));
            nx_cfg.y = CW'($urandom_range(0, 150));
            nx_cfg.scale = 2'($urandom_range(0, 3));
            nx_cfg.mirror = 2'($urandom_range(0, 3));
            nx_cfg.key = 1'($urandom_range(0, 1));
            nx_cfg.en = 1'($urandom_range(0, 7) != 0);
            cyc($urandom_range(0, 500), $urandom_range(0, 700),
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < L + 4; i++) cyc(2047, 2047);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
